// File: rtl/udp_csr_pkg.sv
// Shared definitions for the multi-channel UDP receive-filter CSR bank:
// FSM encoding, register offsets and address/byte-lane helpers.
package udp_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_MEM    = 2'd2,
        ST_RESP   = 2'd3
    } csr_state_t;

    localparam logic [4:0]  OFF_MAC_LO  = 5'h00;
    localparam logic [4:0]  OFF_MAC_HI  = 5'h04;
    localparam logic [4:0]  OFF_IP      = 5'h08;
    localparam logic [4:0]  OFF_PORT    = 5'h0C;
    localparam logic [4:0]  OFF_CTRL    = 5'h10;
    localparam logic [4:0]  OFF_PKT_CNT = 5'h14;

    localparam logic [31:0] GLB_IRQ_STATUS = 32'h0000_0000;
    localparam logic [31:0] GLB_IRQ_MASK   = 32'h0000_0004;

    localparam logic [31:0] DEF_CH_STRIDE  = 32'h0000_0020;

    typedef struct packed {
        logic [31:0] ch;
        logic [4:0]  off;
        logic        off_ok;
    } ch_loc_t;

    // Splits a channel-block address into channel index and word offset;
    // off_ok is clear for gaps (+0x18/+0x1C), unaligned or out-of-group offsets.
    function automatic ch_loc_t chan_locate(input logic [31:0] adr,
                                            input logic [31:0] base,
                                            input logic [31:0] stride);
        ch_loc_t     loc;
        logic [31:0] rel;
        logic [31:0] off;
        rel        = adr - base;
        loc.ch     = rel / stride;
        off        = rel % stride;
        loc.off    = off[4:0];
        loc.off_ok = (off < 32'h0000_0018) && (off[1:0] == 2'b00);
        return loc;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/udp_csr_bank_if.sv
// Wishbone classic slave-side bus bundle for the CSR bank.
interface udp_csr_bank_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_err_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_err_o, wbs_dat_o
    );
endinterface

// File: rtl/udp_csr_chan.sv
// One receive channel's filter registers and packet counter, with a
// byte-lane write port and a combinational read mux.
module udp_csr_chan
    import udp_csr_pkg::*;
#(
    parameter logic [47:0] RST_MAC  = 48'h0,
    parameter logic [31:0] RST_IP   = 32'h0,
    parameter logic [15:0] RST_PORT = 16'h0,
    parameter logic        RST_EN   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  off,
    input  logic [3:0]  sel,
    input  logic [31:0] wr_dat,
    input  logic        inc,
    output logic [31:0] rd_dat,
    output logic [47:0] mac,
    output logic [31:0] ip,
    output logic [15:0] port,
    output logic        en
);

    logic [47:0] mac_r;
    logic [31:0] ip_r;
    logic [15:0] port_r;
    logic        en_r;
    logic [31:0] cnt_r;
    logic [31:0] mac_lo_nx_s;
    logic [31:0] mac_hi_nx_s;
    logic [31:0] ip_nx_s;
    logic [31:0] port_nx_s;

    // Merged write values and the read mux; narrow fields read back zero-extended.
    always_comb begin
        mac_lo_nx_s = lane_merge(mac_r[31:0], wr_dat, sel);
        mac_hi_nx_s = lane_merge({16'h0, mac_r[47:32]}, wr_dat, sel);
        ip_nx_s     = lane_merge(ip_r, wr_dat, sel);
        port_nx_s   = lane_merge({16'h0, port_r}, wr_dat, sel);
        case (off)
            OFF_MAC_LO:  rd_dat = mac_r[31:0];
            OFF_MAC_HI:  rd_dat = {16'h0, mac_r[47:32]};
            OFF_IP:      rd_dat = ip_r;
            OFF_PORT:    rd_dat = {16'h0, port_r};
            OFF_CTRL:    rd_dat = {31'h0, en_r};
            OFF_PKT_CNT: rd_dat = cnt_r;
            default:     rd_dat = 32'h0;
        endcase
    end

    // Register state; the counter keeps running regardless of bus writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_r  <= RST_MAC;
            ip_r   <= RST_IP;
            port_r <= RST_PORT;
            en_r   <= RST_EN;
            cnt_r  <= 32'h0;
        end else begin
            if (wr_en) begin
                case (off)
                    OFF_MAC_LO: mac_r[31:0]  <= mac_lo_nx_s;
                    OFF_MAC_HI: mac_r[47:32] <= mac_hi_nx_s[15:0];
                    OFF_IP:     ip_r         <= ip_nx_s;
                    OFF_PORT:   port_r       <= port_nx_s[15:0];
                    OFF_CTRL:   en_r         <= sel[0] ? wr_dat[0] : en_r;
                    default:    ;
                endcase
            end
            if (inc) begin
                cnt_r <= cnt_r + 32'd1;
            end
        end
    end

    assign mac  = mac_r;
    assign ip   = ip_r;
    assign port = port_r;
    assign en   = en_r;

endmodule

// File: rtl/udp_csr_bank.sv
// Wishbone classic CSR slave for N_CH UDP receive channels: filter registers,
// packet counters, masked interrupt and a wait-stated RX memory read window.
module udp_csr_bank
    import udp_csr_pkg::*;
#(
    parameter int          N_CH        = 4,
    parameter logic [31:0] CSR_BASE    = 32'h3000_0000,
    parameter logic [31:0] CH_STRIDE   = DEF_CH_STRIDE,
    parameter logic [31:0] GLB_BASE    = 32'h3000_0100,
    parameter logic [31:0] RX_MEM_BASE = 32'h4000_0000,
    parameter int          RX_MEM_AW   = 10,
    parameter logic [47:0] RST_MAC     = 48'h01005e0000fb,
    parameter logic [31:0] RST_IP      = 32'he00000fb,
    parameter logic [15:0] RST_PORT    = 16'd5353
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    udp_csr_bank_if.slave          wbs,
    output logic [48*N_CH-1:0]     mac_addr,
    output logic [32*N_CH-1:0]     ip_addr,
    output logic [16*N_CH-1:0]     port,
    output logic [N_CH-1:0]        ch_en,
    output logic                   irq_o,
    input  logic                   rx_pkt_done_i,
    input  logic [2:0]             rx_pkt_ch_i,
    output logic                   rx_mem_rd_o,
    output logic [RX_MEM_AW-1:0]   rx_mem_addr_o,
    input  logic [31:0]            rx_mem_dat_i
);

    localparam logic [31:0] MEM_SPAN = 32'd4 << RX_MEM_AW;

    csr_state_t             state_r;
    logic [31:0]            adr_r;
    logic [31:0]            dat_r;
    logic [3:0]             sel_r;
    logic                   we_r;
    logic                   ack_r;
    logic                   err_r;
    logic [31:0]            dat_o_r;
    logic                   rx_mem_rd_r;
    logic [RX_MEM_AW-1:0]   rx_mem_addr_r;
    logic [N_CH-1:0]        irq_status_r;
    logic [N_CH-1:0]        irq_mask_r;
    logic                   irq_r;

    ch_loc_t                loc_s;
    logic                   chan_hit_s;
    logic                   stat_hit_s;
    logic                   mask_hit_s;
    logic                   reg_hit_s;
    logic [2:0]             ch_sel_s;
    logic [31:0]            chan_rd_s;
    logic [31:0]            reg_rd_s;
    logic                   mem_req_s;
    logic [N_CH-1:0]        inc_s;
    logic [N_CH-1:0]        irq_clr_s;
    logic [N_CH-1:0]        chan_wr_s;
    logic [31:0]            rd_data_s [N_CH];

    // Address decode of the latched request plus packet-event qualification.
    always_comb begin
        loc_s      = chan_locate(adr_r, CSR_BASE, CH_STRIDE);
        chan_hit_s = (adr_r >= CSR_BASE) && (loc_s.ch < 32'(N_CH)) && loc_s.off_ok;
        stat_hit_s = (adr_r == (GLB_BASE + GLB_IRQ_STATUS));
        mask_hit_s = (adr_r == (GLB_BASE + GLB_IRQ_MASK));
        reg_hit_s  = chan_hit_s || stat_hit_s || mask_hit_s;
        ch_sel_s   = loc_s.ch[2:0];
        chan_rd_s  = 32'h0;
        for (int c = 0; c < N_CH; c++) begin
            chan_rd_s    = chan_rd_s | ((ch_sel_s == 3'(c)) ? rd_data_s[c] : 32'h0);
            chan_wr_s[c] = (state_r == ST_DECODE) && we_r && chan_hit_s && (ch_sel_s == 3'(c));
            inc_s[c]     = rx_pkt_done_i && (rx_pkt_ch_i == 3'(c)) && ch_en[c];
        end
        if (chan_hit_s) begin
            reg_rd_s = chan_rd_s;
        end else if (stat_hit_s) begin
            reg_rd_s = 32'(irq_status_r);
        end else if (mask_hit_s) begin
            reg_rd_s = 32'(irq_mask_r);
        end else begin
            reg_rd_s = 32'h0;
        end
        irq_clr_s = ((state_r == ST_DECODE) && we_r && stat_hit_s && sel_r[0]) ?
                    dat_r[N_CH-1:0] : {N_CH{1'b0}};
        mem_req_s = !wbs.wbs_we_i && (wbs.wbs_adr_i >= RX_MEM_BASE) &&
                    ((wbs.wbs_adr_i - RX_MEM_BASE) < MEM_SPAN);
    end

    // Bus FSM. The RX read strobe is issued on the IDLE->DECODE edge so the
    // memory's one-cycle latency lands its data in MEM, keeping the strobe registered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r       <= ST_IDLE;
            adr_r         <= 32'h0;
            dat_r         <= 32'h0;
            sel_r         <= 4'h0;
            we_r          <= 1'b0;
            ack_r         <= 1'b0;
            err_r         <= 1'b0;
            dat_o_r       <= 32'h0;
            rx_mem_rd_r   <= 1'b0;
            rx_mem_addr_r <= {RX_MEM_AW{1'b0}};
            irq_mask_r    <= {N_CH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (wbs.wbs_stb_i && wbs.wbs_cyc_i) begin
                        adr_r   <= wbs.wbs_adr_i;
                        dat_r   <= wbs.wbs_dat_i;
                        sel_r   <= wbs.wbs_sel_i;
                        we_r    <= wbs.wbs_we_i;
                        state_r <= ST_DECODE;
                        if (mem_req_s) begin
                            rx_mem_rd_r   <= 1'b1;
                            rx_mem_addr_r <= wbs.wbs_adr_i[RX_MEM_AW+1:2];
                        end
                    end
                end
                ST_DECODE: begin
                    rx_mem_rd_r <= 1'b0;
                    if (rx_mem_rd_r) begin
                        state_r <= ST_MEM;
                    end else if (reg_hit_s) begin
                        if (!we_r) begin
                            dat_o_r <= reg_rd_s;
                        end
                        if (we_r && mask_hit_s && sel_r[0]) begin
                            irq_mask_r <= dat_r[N_CH-1:0];
                        end
                        ack_r   <= 1'b1;
                        state_r <= ST_RESP;
                    end else begin
                        err_r   <= 1'b1;
                        state_r <= ST_RESP;
                    end
                end
                ST_MEM: begin
                    dat_o_r <= rx_mem_dat_i;
                    ack_r   <= 1'b1;
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Interrupt status: a packet event on the same bit beats a W1C.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_status_r <= {N_CH{1'b0}};
            irq_r        <= 1'b0;
        end else begin
            irq_status_r <= (irq_status_r & ~irq_clr_s) | inc_s;
            irq_r        <= |(irq_status_r & irq_mask_r);
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        udp_csr_chan #(
            .RST_MAC  ((c == 0) ? RST_MAC  : 48'h0),
            .RST_IP   ((c == 0) ? RST_IP   : 32'h0),
            .RST_PORT ((c == 0) ? RST_PORT : 16'h0),
            .RST_EN   ((c == 0) ? 1'b1     : 1'b0)
        ) u_chan (
            .clk    (wb_clk_i),
            .rst    (wb_rst_i),
            .wr_en  (chan_wr_s[c]),
            .off    (loc_s.off),
            .sel    (sel_r),
            .wr_dat (dat_r),
            .inc    (inc_s[c]),
            .rd_dat (rd_data_s[c]),
            .mac    (mac_addr[48*c +: 48]),
            .ip     (ip_addr[32*c +: 32]),
            .port   (port[16*c +: 16]),
            .en     (ch_en[c])
        );
    end

    assign wbs.wbs_ack_o = ack_r;
    assign wbs.wbs_err_o = err_r;
    assign wbs.wbs_dat_o = dat_o_r;
    assign rx_mem_rd_o   = rx_mem_rd_r;
    assign rx_mem_addr_o = rx_mem_addr_r;
    assign irq_o         = irq_r;

endmodule
